// File: rtl/ctrl_decode_stage.sv
// ID/EX control decoder: turns opcode/funct3/funct7 into a registered control word
// with a valid/ready handshake, stall/flush, and an MDU occupancy FSM for RV32M.
//
// state | meaning
// IDLE  | accepting; output register loads a decoded word or a bubble
// BUSY  | multiply/divide in flight; count_q holds the remaining cycles, no accept
module ctrl_decode_stage #(
    parameter bit          ENABLE_M    = 1'b0,
    parameter int unsigned MDU_LATENCY = 32,
    parameter int unsigned ALU_CTRL_W  = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [6:0]            i_opcode,
    input  logic [2:0]            i_funct3,
    input  logic [6:0]            i_funct7,
    input  logic                  i_stall,
    input  logic                  i_flush,
    output logic                  o_valid,
    output logic                  o_alu_op_src_ctrl,
    output logic                  o_branch,
    output logic                  o_jump,
    output logic                  o_rf_we_ctrl,
    output logic                  o_mem_we,
    output logic                  o_mem_re,
    output logic                  o_bu_jb_ctrl,
    output logic [2:0]            o_sx_imm_src_ctrl,
    output logic [2:0]            o_rf_wb_src_ctrl,
    output logic [ALU_CTRL_W-1:0] o_alu_ctrl,
    output logic                  o_illegal,
    output logic                  o_mdu_start,
    output logic                  o_mdu_busy
);
    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic                  valid;
        logic                  illegal;
        logic                  alu_op_src;
        logic                  branch;
        logic                  jump;
        logic                  rf_we;
        logic                  mem_we;
        logic                  mem_re;
        logic                  bu_jb;
        logic                  mdu_start;
        logic [2:0]            imm;
        logic [2:0]            wb;
        logic [ALU_CTRL_W-1:0] alu;
    } ctrl_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = ALU_CTRL_W'(0);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = ALU_CTRL_W'(1);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = ALU_CTRL_W'(2);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = ALU_CTRL_W'(3);
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = ALU_CTRL_W'(4);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR   = ALU_CTRL_W'(5);
    localparam logic [ALU_CTRL_W-1:0] ALU_AND  = ALU_CTRL_W'(6);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = ALU_CTRL_W'(7);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = ALU_CTRL_W'(8);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = ALU_CTRL_W'(9);
    localparam logic [ALU_CTRL_W-1:0] ALU_MUL  = ALU_CTRL_W'(10);

    localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011, IMM_U = 3'b100;
    localparam logic [2:0] WB_MEM = 3'b001, WB_PC4 = 3'b010;
    localparam logic [2:0] WB_IMM = 3'b011, WB_PCIMM = 3'b100;

    localparam logic [7:0] CNT_LOAD = 8'(MDU_LATENCY - 1);

    state_t     state_q;
    logic [7:0] count_q;
    ctrl_t      word_d, word_q;
    logic       illegal;
    logic       accept;

    // alt selects SUB/SRA; callers only raise it where funct7[5] is meaningful
    function automatic logic [ALU_CTRL_W-1:0] base_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        word_d       = '0;
        illegal      = 1'b0;
        word_d.valid = 1'b1;
        case (i_opcode)
            OPC_OP: begin
                word_d.rf_we = 1'b1;
                if (i_funct7 == F7_MULDIV) begin
                    if (ENABLE_M) begin
                        word_d.alu       = ALU_MUL + ALU_CTRL_W'(i_funct3);
                        word_d.mdu_start = 1'b1;
                    end else begin
                        illegal = 1'b1;
                    end
                end else if (i_funct7 == F7_BASE || i_funct7 == F7_ALT) begin
                    word_d.alu = base_alu(i_funct3, i_funct7[5]);
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                word_d.rf_we      = 1'b1;
                word_d.alu_op_src = 1'b1;
                word_d.alu        = base_alu(i_funct3, i_funct7[5] && (i_funct3 == 3'b101));
                if (i_funct3 == 3'b001)
                    illegal = (i_funct7 != F7_BASE);
                else if (i_funct3 == 3'b101)
                    illegal = (i_funct7 != F7_BASE) && (i_funct7 != F7_ALT);
            end
            OPC_LOAD: begin
                word_d.mem_re     = 1'b1;
                word_d.rf_we      = 1'b1;
                word_d.wb         = WB_MEM;
                word_d.imm        = IMM_I;
                word_d.alu_op_src = 1'b1;
            end
            OPC_STORE: begin
                word_d.mem_we     = 1'b1;
                word_d.imm        = IMM_S;
                word_d.alu_op_src = 1'b1;
            end
            OPC_BRANCH: begin
                word_d.alu    = ALU_SUB;
                word_d.branch = 1'b1;
                word_d.bu_jb  = 1'b1;
                word_d.imm    = IMM_B;
            end
            OPC_JAL: begin
                word_d.jump   = 1'b1;
                word_d.branch = 1'b1;
                word_d.rf_we  = 1'b1;
                word_d.wb     = WB_PC4;
                word_d.imm    = IMM_J;
                word_d.bu_jb  = 1'b1;
            end
            OPC_JALR: begin
                word_d.jump       = 1'b1;
                word_d.branch     = 1'b1;
                word_d.rf_we      = 1'b1;
                word_d.wb         = WB_PC4;
                word_d.imm        = IMM_I;
                word_d.alu_op_src = 1'b1;
            end
            OPC_LUI: begin
                word_d.rf_we = 1'b1;
                word_d.wb    = WB_IMM;
                word_d.imm   = IMM_U;
            end
            OPC_AUIPC: begin
                word_d.rf_we = 1'b1;
                word_d.wb    = WB_PCIMM;
                word_d.imm   = IMM_U;
            end
            default: illegal = 1'b1;
        endcase
        // an illegal word is live but carries no side effects
        if (illegal) begin
            word_d         = '0;
            word_d.valid   = 1'b1;
            word_d.illegal = 1'b1;
        end
    end

    assign o_ready = !i_rst && !i_stall && (state_q == IDLE);
    assign accept  = i_valid && o_ready && !i_flush;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            count_q <= '0;
            word_q  <= '0;
        end else begin
            if (i_flush)
                word_q <= '0;
            else if (!i_stall)
                word_q <= accept ? word_d : '0;

            case (state_q)
                IDLE: begin
                    if (accept && word_d.mdu_start) begin
                        state_q <= BUSY;
                        count_q <= CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (i_flush) begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end else begin
                        count_q <= count_q - 8'd1;
                        if (count_q == 8'd1)
                            state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_valid           = word_q.valid;
    assign o_illegal         = word_q.illegal;
    assign o_alu_op_src_ctrl = word_q.alu_op_src;
    assign o_branch          = word_q.branch;
    assign o_jump            = word_q.jump;
    assign o_rf_we_ctrl      = word_q.rf_we;
    assign o_mem_we          = word_q.mem_we;
    assign o_mem_re          = word_q.mem_re;
    assign o_bu_jb_ctrl      = word_q.bu_jb;
    assign o_mdu_start       = word_q.mdu_start;
    assign o_sx_imm_src_ctrl = word_q.imm;
    assign o_rf_wb_src_ctrl  = word_q.wb;
    assign o_alu_ctrl        = word_q.alu;
    assign o_mdu_busy        = (state_q == BUSY);

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Bench for ctrl_decode_stage: instance 0 has RV32M with a 4-cycle MDU, instance 1 is
// base-only. Both share stimulus and are tracked by a cycle-level reference model.
module tb_ctrl_decode_stage;
    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic       alu_op_src;
        logic       branch;
        logic       jump;
        logic       rf_we;
        logic       mem_we;
        logic       mem_re;
        logic       bu_jb;
        logic       mdu_start;
        logic [2:0] imm;
        logic [2:0] wb;
        logic [4:0] alu;
    } exp_t;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] alu;
        logic       rf_we;
        logic       src;
        logic       jump;
        logic       bu_jb;
        logic [2:0] imm;
        logic [2:0] wb;
        logic       ill_m;
        logic       ill_b;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, vld, stall, flush;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [1:0] ready, valid, illegal, src, branch, jump, rf_we, mem_we, mem_re, bu_jb, start, busy;
    logic [2:0] imm [2];
    logic [2:0] wb  [2];
    logic [4:0] alu [2];

    int   checks = 0;
    int   errors = 0;
    exp_t mdl_w    [2];
    int   mdl_busy [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ctrl_decode_stage #(
            .ENABLE_M(g == 0),
            .MDU_LATENCY(g == 0 ? 4 : 32),
            .ALU_CTRL_W(5)
        ) u_dut (
            .i_clk(clk), .i_rst(rst), .i_valid(vld), .o_ready(ready[g]),
            .i_opcode(opc), .i_funct3(f3), .i_funct7(f7),
            .i_stall(stall), .i_flush(flush), .o_valid(valid[g]),
            .o_alu_op_src_ctrl(src[g]), .o_branch(branch[g]), .o_jump(jump[g]),
            .o_rf_we_ctrl(rf_we[g]), .o_mem_we(mem_we[g]), .o_mem_re(mem_re[g]),
            .o_bu_jb_ctrl(bu_jb[g]), .o_sx_imm_src_ctrl(imm[g]), .o_rf_wb_src_ctrl(wb[g]),
            .o_alu_ctrl(alu[g]), .o_illegal(illegal[g]), .o_mdu_start(start[g]),
            .o_mdu_busy(busy[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic exp_t act(input int d);
        exp_t a;
        a.valid = valid[d];   a.illegal = illegal[d]; a.alu_op_src = src[d];
        a.branch = branch[d]; a.jump = jump[d];       a.rf_we = rf_we[d];
        a.mem_we = mem_we[d]; a.mem_re = mem_re[d];   a.bu_jb = bu_jb[d];
        a.mdu_start = start[d]; a.imm = imm[d]; a.wb = wb[d]; a.alu = alu[d];
        return a;
    endfunction

    // Reference decode: instruction-class table lookups, not the RTL's structure
    function automatic exp_t ref_decode(input logic [6:0] op, input logic [2:0] fn3,
                                        input logic [6:0] fn7, input bit en_m);
        exp_t       e;
        bit         bad;
        logic [4:0] base [8];
        base = '{5'd0, 5'd7, 5'd3, 5'd2, 5'd4, 5'd8, 5'd5, 5'd6};
        e = '0;
        bad = 1'b0;
        e.valid = 1'b1;
        case (op)
            7'h33: begin
                e.rf_we = 1'b1;
                if (fn7 == 7'h01 && en_m) begin
                    e.alu = 5'd10 + 5'(fn3);
                    e.mdu_start = 1'b1;
                end else if (fn7 == 7'h00 || fn7 == 7'h20) begin
                    e.alu = base[fn3] + ((fn7[5] && (fn3 == 3'd0 || fn3 == 3'd5)) ? 5'd1 : 5'd0);
                end else begin
                    bad = 1'b1;
                end
            end
            7'h13: begin
                e.rf_we = 1'b1; e.alu_op_src = 1'b1; e.alu = base[fn3];
                if (fn3 == 3'd1 && fn7 != 7'h00) bad = 1'b1;
                if (fn3 == 3'd5) begin
                    if (fn7 == 7'h20) e.alu = 5'd9;
                    else if (fn7 != 7'h00) bad = 1'b1;
                end
            end
            7'h03: begin e.mem_re = 1'b1; e.rf_we = 1'b1; e.wb = 3'd1; e.alu_op_src = 1'b1; end
            7'h23: begin e.mem_we = 1'b1; e.imm = 3'd1; e.alu_op_src = 1'b1; end
            7'h63: begin e.alu = 5'd1; e.branch = 1'b1; e.bu_jb = 1'b1; e.imm = 3'd2; end
            7'h6f: begin
                e.jump = 1'b1; e.branch = 1'b1; e.rf_we = 1'b1; e.wb = 3'd2;
                e.imm = 3'd3; e.bu_jb = 1'b1;
            end
            7'h67: begin
                e.jump = 1'b1; e.branch = 1'b1; e.rf_we = 1'b1; e.wb = 3'd2;
                e.alu_op_src = 1'b1;
            end
            7'h37: begin e.rf_we = 1'b1; e.wb = 3'd3; e.imm = 3'd4; end
            7'h17: begin e.rf_we = 1'b1; e.wb = 3'd4; e.imm = 3'd4; end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            e = '0;
            e.valid = 1'b1;
            e.illegal = 1'b1;
        end
        return e;
    endfunction

    // One clock edge of the reference: remaining-busy-cycle counter plus output word
    task automatic mdl_edge(input int d);
        bit rdy, acc;
        if (rst) begin
            mdl_w[d] = '0;
            mdl_busy[d] = 0;
        end else begin
            rdy = !stall && (mdl_busy[d] == 0);
            acc = vld && rdy && !flush;
            if (mdl_busy[d] > 0) mdl_busy[d]--;
            if (flush) begin
                mdl_w[d] = '0;
                mdl_busy[d] = 0;
            end else if (!stall) begin
                mdl_w[d] = acc ? ref_decode(opc, f3, f7, d == 0) : '0;
                if (acc && mdl_w[d].mdu_start) mdl_busy[d] = (d == 0 ? 4 : 32) - 1;
            end
        end
    endtask

    task automatic cmp(input int d);
        exp_t a, e;
        logic exp_rdy;
        a = act(d);
        e = mdl_w[d];
        exp_rdy = !rst && !stall && (mdl_busy[d] == 0);
        chk($sformatf("m%0d_ready", d), 32'(ready[d]), 32'(exp_rdy));
        chk($sformatf("m%0d_busy", d), 32'(busy[d]), 32'(mdl_busy[d] != 0));
        chk($sformatf("m%0d_valid", d), 32'(a.valid), 32'(e.valid));
        chk($sformatf("m%0d_enables", d),
            32'({a.rf_we, a.mem_we, a.mem_re, a.branch, a.jump, a.mdu_start}),
            32'({e.rf_we, e.mem_we, e.mem_re, e.branch, e.jump, e.mdu_start}));
        if (e.valid) chk($sformatf("m%0d_illegal", d), 32'(a.illegal), 32'(e.illegal));
        if (e.valid && !e.illegal) begin
            chk($sformatf("m%0d_alu", d), 32'(a.alu), 32'(e.alu));
            chk($sformatf("m%0d_imm_wb", d), 32'({a.imm, a.wb}), 32'({e.imm, e.wb}));
            chk($sformatf("m%0d_src_bujb", d), 32'({a.alu_op_src, a.bu_jb}),
                32'({e.alu_op_src, e.bu_jb}));
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int d = 0; d < 2; d++) mdl_edge(d);
        #1;
        for (int d = 0; d < 2; d++) cmp(d);
    endtask

    vec_t       tbl [17];
    logic [6:0] ops [9];
    vec_t       v;
    int         idx;

    initial begin
        tbl = '{
            '{7'h33, 3'd0, 7'h00, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0},
            '{7'h33, 3'd0, 7'h20, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0},
            '{7'h13, 3'd0, 7'h20, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0},
            '{7'h13, 3'd5, 7'h20, 5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0},
            '{7'h6f, 3'd0, 7'h00, 5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 3'd2, 1'b0, 1'b0},
            '{7'h67, 3'd0, 7'h00, 5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 3'd2, 1'b0, 1'b0},
            '{7'h7f, 3'd0, 7'h00, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1},
            '{7'h33, 3'd0, 7'h01, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1},
            '{7'h33, 3'd5, 7'h01, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1},
            '{7'h37, 3'd0, 7'h00, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 3'd3, 1'b0, 1'b0},
            '{7'h17, 3'd0, 7'h00, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 3'd4, 1'b0, 1'b0},
            '{7'h13, 3'd1, 7'h20, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1},
            '{7'h33, 3'd0, 7'h10, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1},
            '{7'h23, 3'd2, 7'h00, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 3'd0, 1'b0, 1'b0},
            '{7'h63, 3'd0, 7'h00, 5'd1,  1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 3'd0, 1'b0, 1'b0},
            '{7'h03, 3'd2, 7'h00, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0},
            '{7'h33, 3'd5, 7'h20, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0}
        };
        ops = '{7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h33, 7'h13};

        rst = 1'b1; vld = 1'b0; stall = 1'b0; flush = 1'b0;
        opc = 7'h00; f3 = 3'd0; f7 = 7'h00;
        step();
        step();
        for (int d = 0; d < 2; d++) chk($sformatf("reset_word%0d", d), 32'(act(d)), 32'd0);
        rst = 1'b0;
        #1;
        chk("reset_release_ready", 32'(ready), 32'b11);

        // decode table: one accept, then idle long enough to drain any MDU occupancy
        for (int i = 0; i < 17; i++) begin
            v = tbl[i];
            opc = v.op; f3 = v.f3; f7 = v.f7; vld = 1'b1;
            step();
            vld = 1'b0;
            chk($sformatf("tbl%0d_valid", i), 32'(valid[0]), 32'd1);
            chk($sformatf("tbl%0d_ill_m", i), 32'(illegal[0]), 32'(v.ill_m));
            chk($sformatf("tbl%0d_ill_b", i), 32'(illegal[1]), 32'(v.ill_b));
            chk($sformatf("tbl%0d_rf_we", i), 32'(rf_we[0]), 32'(v.rf_we));
            if (!v.ill_m) begin
                chk($sformatf("tbl%0d_alu", i), 32'(alu[0]), 32'(v.alu));
                chk($sformatf("tbl%0d_src", i), 32'(src[0]), 32'(v.src));
                chk($sformatf("tbl%0d_jump_bujb", i), 32'({jump[0], bu_jb[0]}),
                    32'({v.jump, v.bu_jb}));
                chk($sformatf("tbl%0d_imm_wb", i), 32'({imm[0], wb[0]}), 32'({v.imm, v.wb}));
            end else begin
                chk($sformatf("tbl%0d_ill_mem", i), 32'({mem_we[0], mem_re[0]}), 32'd0);
            end
            repeat (4) step();
        end

        // DIVU occupancy with a 4-cycle MDU, ADD waiting behind it
        opc = 7'h33; f3 = 3'd5; f7 = 7'h01; vld = 1'b1;
        step();
        chk("divu_alu", 32'(alu[0]), 32'd15);
        chk("divu_start", 32'(start[0]), 32'd1);
        chk("divu_busy_c1", 32'(busy[0]), 32'd1);
        chk("divu_ready_c1", 32'(ready[0]), 32'd0);
        f3 = 3'd0; f7 = 7'h00;
        for (int c = 2; c <= 3; c++) begin
            step();
            chk($sformatf("divu_busy_c%0d", c), 32'(busy[0]), 32'd1);
            chk($sformatf("divu_ready_c%0d", c), 32'(ready[0]), 32'd0);
            chk($sformatf("divu_bubble_c%0d", c), 32'({valid[0], start[0]}), 32'd0);
        end
        step();
        chk("divu_busy_c4", 32'(busy[0]), 32'd0);
        chk("divu_ready_c4", 32'(ready[0]), 32'd1);
        step();
        chk("divu_next_valid", 32'(valid[0]), 32'd1);
        chk("divu_next_alu", 32'(alu[0]), 32'd0);
        vld = 1'b0;
        step();

        // LOAD held by a 3-cycle stall, then flush+stall+valid together
        opc = 7'h03; f3 = 3'd2; vld = 1'b1;
        step();
        stall = 1'b1; opc = 7'h33; f3 = 3'd0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("stall_hold_word", 32'({valid[0], mem_re[0], rf_we[0], wb[0]}), 32'({3'b111, 3'd1}));
            chk("stall_ready", 32'(ready[0]), 32'd0);
        end
        flush = 1'b1;
        step();
        chk("flush_stall_valid", 32'(valid), 32'd0);
        chk("flush_stall_mem_re", 32'(mem_re[0]), 32'd0);
        flush = 1'b0; stall = 1'b0; vld = 1'b0;
        step();

        // reset in the middle of an MDU operation
        opc = 7'h33; f3 = 3'd0; f7 = 7'h01; vld = 1'b1;
        step();
        vld = 1'b0;
        chk("rst_busy_before", 32'(busy[0]), 32'd1);
        rst = 1'b1;
        step();
        chk("rst_busy_after", 32'(busy[0]), 32'd0);
        chk("rst_word_after", 32'(act(0)), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready_after", 32'(ready[0]), 32'd1);

        // flush in the middle of an MDU operation
        vld = 1'b1;
        step();
        vld = 1'b0;
        step();
        chk("flush_busy_before", 32'(busy[0]), 32'd1);
        flush = 1'b1;
        step();
        chk("flush_busy_after", 32'(busy[0]), 32'd0);
        chk("flush_valid_after", 32'(valid[0]), 32'd0);
        flush = 1'b0;
        #1;
        chk("flush_ready_after", 32'(ready[0]), 32'd1);
        step();

        // randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 99) < 2);
            vld   = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            idx   = int'($urandom_range(0, 10));
            opc   = (idx < 9) ? ops[idx] : 7'($urandom);
            f3    = 3'($urandom);
            case ($urandom_range(0, 4))
                0, 1:    f7 = 7'h00;
                2:       f7 = 7'h20;
                3:       f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
